// File: rtl/uart_transmitter_controller_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
// The overrun feature is enabled by defining TX_CTRL_OVERRUN_FLAG_EN.
package uart_transmitter_controller_pkg;

  localparam int unsigned TX_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_HOLD = 2'b10
  } tx_state_e;

  typedef enum logic {
    SEL_FIRST = 1'b0,
    SEL_LAST  = 1'b1
  } byte_sel_e;

endpackage

// File: rtl/uart_transmitter_controller_if.sv
// Result/strobe inputs and UART TX request outputs of the transmit scheduler.
// The overrun signal exists only when TX_CTRL_OVERRUN_FLAG_EN is defined.
interface uart_transmitter_controller_if
  import uart_transmitter_controller_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = TX_DATA_WIDTH
);
  localparam int unsigned ALU_OUT_WIDTH = 2 * DATA_WIDTH;

  logic [ALU_OUT_WIDTH-1:0] alu_out;
  logic                     alu_out_valid;
  logic [DATA_WIDTH-1:0]    rd_data;
  logic                     rd_data_valid;
  logic                     tx_busy;
  logic [DATA_WIDTH-1:0]    tx_p_data;
  logic                     tx_data_valid;
`ifdef TX_CTRL_OVERRUN_FLAG_EN
  logic                     overrun;
`endif

  modport master (
    input  alu_out,
    input  alu_out_valid,
    input  rd_data,
    input  rd_data_valid,
    input  tx_busy,
    output tx_p_data,
    output tx_data_valid
`ifdef TX_CTRL_OVERRUN_FLAG_EN
    , output overrun
`endif
  );

  modport slave (
    output alu_out,
    output alu_out_valid,
    output rd_data,
    output rd_data_valid,
    output tx_busy,
    input  tx_p_data,
    input  tx_data_valid
`ifdef TX_CTRL_OVERRUN_FLAG_EN
    , input overrun
`endif
  );

endinterface

// File: rtl/uart_transmitter_controller_tx_pending_slot.sv
// One-entry holding slot: loads on strobe when empty or draining, else reports a drop.
module tx_pending_slot #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             drop_c_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             full_q, full_d;
  logic             accept_c;

  // A slot being drained this cycle counts as empty, so a refill lands cleanly.
  always_comb begin
    accept_c = load_i & (~full_q | clr_i);
    drop_c_o = load_i & full_q & ~clr_i;
    data_d   = data_q;
    full_d   = full_q;
    if (accept_c) begin
      data_d = data_i;
      full_d = 1'b1;
    end else if (clr_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/uart_transmitter_controller.sv
// Schedules register-read bytes and 2-byte ALU results onto the UART TX byte handshake.
// Define TX_CTRL_OVERRUN_FLAG_EN to expose a one-cycle overrun pulse on dropped strobes.
module uart_transmitter_controller
  import uart_transmitter_controller_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = TX_DATA_WIDTH
) (
  input logic clk,
  input logic reset_n,
  uart_transmitter_controller_if.master tx_if
);

  localparam int unsigned ALU_OUT_WIDTH = 2 * DATA_WIDTH;

  tx_state_e               state_q, state_d;
  byte_sel_e               sel_q, sel_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic                    tx_valid_q, tx_valid_d;

  logic [DATA_WIDTH-1:0]    rd_word;
  logic [ALU_OUT_WIDTH-1:0] alu_word;
  logic                     rd_full, alu_full;
  logic                     rd_clr_c, alu_clr_c;
  logic                     rd_drop_c, alu_drop_c;

  tx_pending_slot #(.WIDTH(DATA_WIDTH)) u_rd_slot (
    .clk      (clk),
    .reset_n  (reset_n),
    .load_i   (tx_if.rd_data_valid),
    .data_i   (tx_if.rd_data),
    .clr_i    (rd_clr_c),
    .data_o   (rd_word),
    .full_o   (rd_full),
    .drop_c_o (rd_drop_c)
  );

  tx_pending_slot #(.WIDTH(ALU_OUT_WIDTH)) u_alu_slot (
    .clk      (clk),
    .reset_n  (reset_n),
    .load_i   (tx_if.alu_out_valid),
    .data_i   (tx_if.alu_out),
    .clr_i    (alu_clr_c),
    .data_o   (alu_word),
    .full_o   (alu_full),
    .drop_c_o (alu_drop_c)
  );

  // Register reads win arbitration; ALU results go out low byte then high byte.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    tx_data_d = tx_data_q;
    rd_clr_c  = 1'b0;
    alu_clr_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rd_full) begin
          tx_data_d = rd_word;
          rd_clr_c  = 1'b1;
          sel_d     = SEL_LAST;
          state_d   = ST_REQ;
        end else if (alu_full) begin
          tx_data_d = alu_word[DATA_WIDTH-1:0];
          sel_d     = SEL_FIRST;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (tx_if.tx_busy) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!tx_if.tx_busy) begin
          if (sel_q == SEL_FIRST) begin
            tx_data_d = alu_word[ALU_OUT_WIDTH-1:DATA_WIDTH];
            alu_clr_c = 1'b1;
            sel_d     = SEL_LAST;
            state_d   = ST_REQ;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    tx_valid_d = (state_d == ST_REQ);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      sel_q      <= SEL_FIRST;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign tx_if.tx_p_data     = tx_data_q;
  assign tx_if.tx_data_valid = tx_valid_q;

`ifdef TX_CTRL_OVERRUN_FLAG_EN
  logic overrun_q, overrun_d;

  // Simultaneous drops on both slots merge into a single pulse.
  always_comb begin
    overrun_d = rd_drop_c | alu_drop_c;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign tx_if.overrun = overrun_q;
`else
  logic unused_drop_c;
  assign unused_drop_c = rd_drop_c | alu_drop_c;
`endif

endmodule

// File: tb/tb_uart_transmitter_controller.sv
// Directed bench for uart_transmitter_controller: byte order, latency, drops and reset.
module tb_uart_transmitter_controller;
  import uart_transmitter_controller_pkg::*;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_err;

  uart_transmitter_controller_if #(.DATA_WIDTH(8)) tx_if ();

  uart_transmitter_controller #(.DATA_WIDTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .tx_if   (tx_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic rd_en, input logic [7:0] rd,
                        input logic alu_en, input logic [15:0] alu);
    tx_if.rd_data_valid = rd_en;
    tx_if.rd_data       = rd;
    tx_if.alu_out_valid = alu_en;
    tx_if.alu_out       = alu;
    tick();
    tx_if.rd_data_valid = 1'b0;
    tx_if.alu_out_valid = 1'b0;
  endtask

  // Waits (bounded) for a request; checks its cycle count and byte.
  task automatic expect_req(input string tag, input logic [7:0] exp, input int lat);
    int  n;
    bit  seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      tick();
      n++;
      if (tx_if.tx_data_valid === 1'b1) seen = 1'b1;
    end
    check({tag, " latency"}, seen ? n : 999, lat);
    check({tag, " byte"}, tx_if.tx_p_data, exp);
  endtask

  task automatic ack(input string tag, input int busy_cycles);
    tx_if.tx_busy = 1'b1;
    tick();
    check({tag, " valid drop"}, tx_if.tx_data_valid, 1'b0);
    repeat (busy_cycles - 1) tick();
    tx_if.tx_busy = 1'b0;
  endtask

  task automatic quiet(input string tag, input int cycles);
    int cnt;
    cnt = 0;
    repeat (cycles) begin
      tick();
      if (tx_if.tx_data_valid !== 1'b0) cnt++;
    end
    check({tag, " no extra req"}, cnt, 0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_n = 1'b0;
    tx_if.rd_data_valid = 1'b0;
    tx_if.rd_data       = '0;
    tx_if.alu_out_valid = 1'b0;
    tx_if.alu_out       = '0;
    tx_if.tx_busy       = 1'b0;
    #1;
    check("reset valid", tx_if.tx_data_valid, 1'b0);
    check("reset data", tx_if.tx_p_data, 8'h00);
`ifdef TX_CTRL_OVERRUN_FLAG_EN
    check("reset overrun", tx_if.overrun, 1'b0);
`endif
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Single register read, 10-cycle busy
    strobe(1'b1, 8'h5A, 1'b0, 16'h0);
    check("rd5A early", tx_if.tx_data_valid, 1'b0);
    expect_req("rd5A", 8'h5A, 1);
    ack("rd5A", 10);
    check("rd5A data kept", tx_if.tx_p_data, 8'h5A);
    quiet("rd5A", 4);

    // ALU result, low byte first
    strobe(1'b0, 8'h00, 1'b1, 16'hBEEF);
    expect_req("aluEF", 8'hEF, 1);
    ack("aluEF", 3);
    expect_req("aluBE", 8'hBE, 1);
    ack("aluBE", 2);
    quiet("aluBEEF", 6);

    // Both strobes together: RD first, then ALU low, ALU high
    strobe(1'b1, 8'h77, 1'b1, 16'h1234);
    expect_req("both77", 8'h77, 1);
    ack("both77", 1);
    expect_req("both34", 8'h34, 2);
    ack("both34", 1);
    expect_req("both12", 8'h12, 1);
    ack("both12", 1);
    quiet("both", 5);

    // Refill accepted in the same cycle the RD slot drains
    strobe(1'b1, 8'h11, 1'b0, 16'h0);
    strobe(1'b1, 8'h22, 1'b0, 16'h0);
    check("refill first valid", tx_if.tx_data_valid, 1'b1);
    check("refill first byte", tx_if.tx_p_data, 8'h11);
`ifdef TX_CTRL_OVERRUN_FLAG_EN
    check("refill no overrun", tx_if.overrun, 1'b0);
`endif
    ack("refill11", 1);
    expect_req("refill22", 8'h22, 2);
    ack("refill22", 1);
    quiet("refill", 4);

    // Second read while first is queued behind an ALU transfer is dropped
    strobe(1'b0, 8'h00, 1'b1, 16'hA5C3);
    expect_req("drpC3", 8'hC3, 1);
    strobe(1'b1, 8'h01, 1'b0, 16'h0);
    strobe(1'b1, 8'h02, 1'b0, 16'h0);
    check("drp valid held", tx_if.tx_data_valid, 1'b1);
    check("drp byte held", tx_if.tx_p_data, 8'hC3);
`ifdef TX_CTRL_OVERRUN_FLAG_EN
    check("drp overrun pulse", tx_if.overrun, 1'b1);
    tick();
    check("drp overrun end", tx_if.overrun, 1'b0);
`endif
    ack("drpC3", 1);
    expect_req("drpA5", 8'hA5, 1);
    ack("drpA5", 1);
    expect_req("drp01", 8'h01, 2);
    ack("drp01", 1);
    quiet("drp", 6);

    // Reset asserted in HOLD between ALU bytes
    strobe(1'b0, 8'h00, 1'b1, 16'h5566);
    expect_req("rst66", 8'h66, 1);
    tx_if.tx_busy = 1'b1;
    tick();
    reset_n = 1'b0;
    #1;
    check("rst valid", tx_if.tx_data_valid, 1'b0);
    check("rst data", tx_if.tx_p_data, 8'h00);
    tx_if.tx_busy = 1'b0;
    tick();
    reset_n = 1'b1;
    quiet("rst no high byte", 8);
    check("rst data after", tx_if.tx_p_data, 8'h00);
    strobe(1'b1, 8'h99, 1'b0, 16'h0);
    expect_req("rst99", 8'h99, 1);
    ack("rst99", 1);
    quiet("rst99", 3);

    // Busy already high on REQ entry: one REQ cycle, next byte waits
    tx_if.tx_busy = 1'b1;
    strobe(1'b1, 8'h3C, 1'b1, 16'h9E8F);
    expect_req("pre3C", 8'h3C, 1);
    tick();
    check("pre3C one cycle", tx_if.tx_data_valid, 1'b0);
    quiet("pre wait", 3);
    tx_if.tx_busy = 1'b0;
    expect_req("pre8F", 8'h8F, 2);
    ack("pre8F", 1);
    expect_req("pre9E", 8'h9E, 1);
    ack("pre9E", 1);
    quiet("pre", 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
